// File: rtl/fib_sweeper.sv
// fib_sweeper: sweeps an index range through the fib core and checks each result
module fib_sweeper #(
  parameter int GAP_CYCLES = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [4:0]  first_idx,
  input  logic [4:0]  last_idx,
  output logic [4:0]  fib_i,
  output logic        fib_start,
  input  logic        fib_done,
  input  logic [19:0] fib_result,
  output logic        busy,
  output logic        sweep_done,
  output logic        pass,
  output logic        timeout,
  output logic [4:0]  fail_idx,
  output logic [19:0] fail_got,
  output logic [5:0]  checked_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, WARM, ISSUE, WAIT, CHECK, GAP, FIN} state_t;
  state_t state, state_nx;
  logic [4:0] first, last, k;
  logic [19:0] a, b, cap;
  logic [TW-1:0] wcnt;
  logic [GW-1:0] gcnt;
  logic match, wait_end, gap_end;
  assign match = cap == a;
  assign wait_end = int'(wcnt) >= TIMEOUT - 1;
  assign gap_end = int'(gcnt) >= GAP_CYCLES - 1;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state and handshake/status decode
  always_comb begin
    state_nx = state;
    fib_start = state == ISSUE;
    sweep_done = state == FIN;
    busy = state != IDLE && state != FIN;
    case (state)
      IDLE:    if (go) state_nx = first_idx > last_idx ? FIN : WARM;
      WARM:    if (k == first) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = fib_done ? CHECK : wait_end ? FIN : WAIT;
      CHECK:   state_nx = !match || k == last ? FIN : GAP;
      GAP:     if (gap_end) state_nx = ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  // expected-value generator, counters and verdict registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      first <= '0;
      last <= '0;
      k <= '0;
      a <= '0;
      b <= 20'd1;
      cap <= '0;
      wcnt <= '0;
      gcnt <= '0;
      fib_i <= '0;
      pass <= 1'b0;
      timeout <= 1'b0;
      fail_idx <= '0;
      fail_got <= '0;
      checked_cnt <= '0;
    end else begin
      if (state_nx == ISSUE) fib_i <= k;
      case (state)
        IDLE: if (go) begin
          first <= first_idx;
          last <= last_idx;
          k <= '0;
          a <= '0;
          b <= 20'd1;
          pass <= first_idx > last_idx;
          timeout <= 1'b0;
          fail_idx <= '0;
          fail_got <= '0;
          checked_cnt <= '0;
        end
        WARM: if (k != first) begin
          a <= b;
          b <= a + b;
          k <= k + 5'd1;
        end
        ISSUE: wcnt <= '0;
        WAIT:
          if (fib_done) cap <= fib_result;
          else if (wait_end) begin
            timeout <= 1'b1;
            fail_idx <= k;
          end else wcnt <= wcnt + TW'(1);
        CHECK:
          if (match) begin
            checked_cnt <= checked_cnt + 6'd1;
            gcnt <= '0;
            if (k == last) pass <= 1'b1;
            else begin
              a <= b;
              b <= a + b;
              k <= k + 5'd1;
            end
          end else begin
            fail_idx <= k;
            fail_got <= cap;
            pass <= 1'b0;
          end
        GAP: if (!gap_end) gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
endmodule
